// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    // Fetch sequencer states
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        OUT,
        HALT
    } fetch_state_e;

    localparam logic [31:0] RESET_PC   = 32'h8000_0000;
    // Clears the two byte-offset bits of an instruction address
    localparam logic [31:0] ALIGN_MASK = ~32'd3;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC select: trap entry beats redirect beats sequential increment.
// A misaligned redirect (without a trap) leaves the PC untouched and is flagged.
module fetch_pc_next #(
    parameter int N = 32
) (
    input  logic [N-1:0] pc,
    input  logic         inc_en,
    input  logic         trap_valid,
    input  logic [N-1:0] trap_vector,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_target,
    output logic [N-1:0] pc_next,
    output logic         misaligned
);
    import fetch_pkg::*;

    localparam logic [N-1:0] ALIGN_N = {{(N-2){1'b1}}, ALIGN_MASK[1:0]};

    // Priority select of the next program counter
    always_comb begin
        misaligned = redirect_valid && !trap_valid && (redirect_target[1:0] != 2'b00);
        if (trap_valid)
            pc_next = trap_vector & ALIGN_N;
        else if (redirect_valid && !misaligned)
            pc_next = redirect_target;
        else if (redirect_valid)
            pc_next = pc;               // faulting redirect: hold, no increment
        else if (inc_en)
            pc_next = pc + N'(4);       // wraps modulo 2^N
        else
            pc_next = pc;
    end

endmodule

// File: rtl/fetch_reg.sv
// Resettable register primitive with load enable and a configurable reset value.
module fetch_reg #(
    parameter int            W    = 32,
    parameter logic [W-1:0]  INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load d when enabled; reset forces INIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= INIT;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: owns the PC, issues one imem request at a time,
// buffers the returned instruction for decode, and handles redirect/trap
// entry by discarding in-flight fetches that became stale.
module fetch_controller #(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = N'(fetch_pkg::RESET_PC)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_target,
    input  logic         trap_valid,
    input  logic [N-1:0] trap_vector,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [N-1:0] imem_req_addr,
    input  logic         imem_resp_valid,
    input  logic [N-1:0] imem_resp_data,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [N-1:0] inst_data,
    output logic [N-1:0] inst_pc,
    output logic         misaligned_fault
);
    import fetch_pkg::*;

    fetch_state_e state_q, state_d;
    logic         kill_q, kill_d;          // outstanding response must be dropped
    logic         halt_pend_q, halt_pend_d; // enter HALT once the killed response returns
    logic         fault_q;
    logic [N-1:0] pc_q, pc_d;
    logic         mis, take, inc_en, ld_inst;

    assign inc_en = (state_q == OUT) && inst_ready;
    assign take   = trap_valid || (redirect_valid && !mis);

    fetch_pc_next #(.N(N)) u_pc_next (
        .pc              (pc_q),
        .inc_en          (inc_en),
        .trap_valid      (trap_valid),
        .trap_vector     (trap_vector),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc_next         (pc_d),
        .misaligned      (mis)
    );

    fetch_reg #(.W(N), .INIT(RESET_PC)) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (pc_d),
        .q   (pc_q)
    );

    // State and control flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            kill_q      <= 1'b0;
            halt_pend_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            halt_pend_q <= halt_pend_d;
            fault_q     <= mis;
        end
    end

    // Next-state: sequencing plus redirect/trap/fault handling
    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        halt_pend_d = halt_pend_q;
        case (state_q)
            IDLE: state_d = mis ? HALT : REQ;
            REQ: begin
                if (imem_req_ready) begin
                    // old request is accepted regardless; a redirect kills it
                    state_d = WAIT;
                    if (take) begin
                        kill_d      = 1'b1;
                        halt_pend_d = 1'b0;
                    end else if (mis) begin
                        kill_d      = 1'b1;
                        halt_pend_d = 1'b1;
                    end
                end else if (mis) begin
                    state_d = HALT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    kill_d      = 1'b0;
                    halt_pend_d = 1'b0;
                    if (take)
                        state_d = REQ;
                    else if (mis)
                        state_d = HALT;
                    else if (kill_q)
                        state_d = halt_pend_q ? HALT : REQ;
                    else
                        state_d = OUT;
                end else if (take) begin
                    kill_d      = 1'b1;
                    halt_pend_d = 1'b0;
                end else if (mis) begin
                    kill_d      = 1'b1;
                    halt_pend_d = 1'b1;
                end
            end
            OUT: begin
                if (take)
                    state_d = REQ;
                else if (mis)
                    state_d = HALT;
                else if (inst_ready)
                    state_d = REQ;
            end
            HALT: if (take) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; buffer load on a live response
    always_comb begin
        imem_req_valid   = (state_q == REQ);
        inst_valid       = (state_q == OUT);
        imem_req_addr    = pc_q;
        misaligned_fault = fault_q;
        ld_inst          = (state_q == WAIT) && imem_resp_valid && !kill_q && !take && !mis;
    end

    // Decode-side instruction buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_data <= '0;
            inst_pc   <= '0;
        end else if (ld_inst) begin
            inst_data <= imem_resp_data;
            inst_pc   <= pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized + directed bench for fetch_controller against a transaction-level
// model: an architectural "next PC to deliver", a halted flag, and a memory
// that answers each accepted request after a random delay.
module tb_fetch_controller;

    localparam int          N   = 32;
    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid, trap_valid;
    logic [31:0] redirect_target, trap_vector;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;
    logic        misaligned_fault;

    always #5 clk = ~clk;

    fetch_controller #(.N(N), .RESET_PC(RPC)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_vector     (trap_vector),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .misaligned_fault(misaligned_fault)
    );

    int vecs = 0;
    int errs = 0;

    // model state
    logic [31:0] exp_pc;
    bit          halted, fault_exp, prev_req_stall, prev_out_stall;
    // memory state
    bit          out_pend;
    logic [31:0] out_addr;
    int          out_cnt, dly, cyc, idle_cnt;
    logic [31:0] acc_addr[$];
    int          acc_cyc[$], dlv_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        exp_pc = RPC; halted = 0; fault_exp = 0;
        prev_req_stall = 0; prev_out_stall = 0; idle_cnt = 0; out_pend = 0;
    endtask

    // One clock cycle: inputs already driven; check, update model, advance.
    task automatic tick();
        bit fault_nxt, evt;
        if (imem_req_valid) begin
            chk("req_addr", imem_req_addr, exp_pc);
            chk("single_outstanding", out_pend, 0);
        end
        if (halted) begin
            chk("halt_no_req", imem_req_valid, 0);
            chk("halt_no_inst", inst_valid, 0);
        end
        if (inst_valid) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst_data", inst_data, mem_word(exp_pc));
        end
        chk("fault", misaligned_fault, fault_exp);
        if (prev_req_stall) chk("req_hold", imem_req_valid, 1);
        if (prev_out_stall) chk("inst_hold", inst_valid, 1);

        evt = redirect_valid || trap_valid;
        if (halted || evt || (imem_req_valid && imem_req_ready) || (inst_valid && inst_ready))
            idle_cnt = 0;
        else
            idle_cnt++;
        if (idle_cnt == 64) chk("progress", idle_cnt, 0);

        fault_nxt = redirect_valid && !trap_valid && (redirect_target[1:0] != 2'b00);
        if (trap_valid) begin
            exp_pc = trap_vector & ~32'd3; halted = 0;
        end else if (redirect_valid && !fault_nxt) begin
            exp_pc = redirect_target; halted = 0;
        end else if (redirect_valid) begin
            halted = 1;
        end else if (inst_valid && inst_ready) begin
            exp_pc = exp_pc + 32'd4;
        end
        fault_exp      = fault_nxt;
        prev_req_stall = imem_req_valid && !imem_req_ready && !evt;
        prev_out_stall = inst_valid && !inst_ready && !evt;
        if (inst_valid && inst_ready) dlv_cyc.push_back(cyc);
        if (imem_req_valid && imem_req_ready) begin
            out_pend = 1; out_addr = imem_req_addr; out_cnt = dly;
            acc_addr.push_back(imem_req_addr); acc_cyc.push_back(cyc);
        end

        @(posedge clk); #1;
        cyc++;
        imem_resp_valid = 1'b0;
        if (out_pend) begin
            if (out_cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(out_addr);
                out_pend = 0;
            end else begin
                out_cnt--;
            end
        end
    endtask

    task automatic wait_accept(output logic [31:0] a);
        int n0 = acc_addr.size();
        int n  = 0;
        while (acc_addr.size() == n0 && n < 30) begin tick(); n++; end
        chk("accept_seen", acc_addr.size() - n0, 1);
        a = acc_addr[$];
    endtask

    task automatic wait_inst(input int maxc);
        int n = 0;
        while (!inst_valid && n < maxc) begin tick(); n++; end
        chk("inst_seen", inst_valid, 1);
    endtask

    task automatic wait_req(input int maxc);
        int n = 0;
        while (!imem_req_valid && n < maxc) begin tick(); n++; end
        chk("req_seen", imem_req_valid, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, imem_req_valid, 0);
        chk({tag, "_inst_valid"}, inst_valid, 0);
        chk({tag, "_inst_data"}, inst_data, 0);
        chk({tag, "_inst_pc"}, inst_pc, 0);
        chk({tag, "_fault"}, misaligned_fault, 0);
    endtask

    logic [31:0] a, d, p;

    initial begin
        rst = 1'b1; cyc = 0; dly = 0;
        redirect_valid = 0; redirect_target = 0; trap_valid = 0; trap_vector = 0;
        imem_req_ready = 1; imem_resp_valid = 0; imem_resp_data = 0; inst_ready = 1;
        model_reset();
        @(posedge clk); #1;
        chk_reset_outputs("rst");
        chk("rst_pc", imem_req_addr, RPC);
        @(posedge clk); #1;
        rst = 1'b0;

        // sequential fetch, zero-wait memory, decode always ready
        acc_addr.delete(); acc_cyc.delete(); dlv_cyc.delete();
        repeat (12) tick();
        chk("seq_n_accepts", acc_addr.size() >= 3, 1);
        chk("seq_n_delivers", dlv_cyc.size() >= 3, 1);
        if (acc_addr.size() >= 3 && dlv_cyc.size() >= 3) begin
            chk("seq_addr0", acc_addr[0], 32'h8000_0000);
            chk("seq_addr1", acc_addr[1], 32'h8000_0004);
            chk("seq_addr2", acc_addr[2], 32'h8000_0008);
            chk("seq_latency", dlv_cyc[0] - acc_cyc[0], 2);
            chk("seq_rate1", dlv_cyc[1] - dlv_cyc[0], 3);
            chk("seq_rate2", dlv_cyc[2] - dlv_cyc[1], 3);
        end

        // decode stalls for 5 cycles
        inst_ready = 0;
        wait_inst(20);
        d = inst_data; p = inst_pc;
        repeat (5) begin
            tick();
            chk("stall_data", inst_data, d);
            chk("stall_pc", inst_pc, p);
            chk("stall_noreq", imem_req_valid, 0);
        end
        inst_ready = 1;
        tick();
        wait_inst(20);
        chk("stall_adv4", inst_pc, p + 32'd4);

        // redirect while waiting on memory kills the response
        dly = 1;
        wait_accept(a);
        redirect_valid = 1; redirect_target = 32'h8000_0100;
        tick();
        redirect_valid = 0;
        chk("kill_noinst0", inst_valid, 0);
        tick();
        chk("kill_noinst1", inst_valid, 0);
        wait_accept(a);
        chk("kill_next_addr", a, 32'h8000_0100);
        dly = 0;

        // trap beats redirect; vector low bits cleared, no fault
        imem_req_ready = 0;
        wait_req(20);
        trap_valid = 1; trap_vector = 32'h8000_0203;
        redirect_valid = 1; redirect_target = 32'h8000_0040;
        tick();
        trap_valid = 0; redirect_valid = 0;
        chk("trap_addr", imem_req_addr, 32'h8000_0200);
        chk("trap_nofault", misaligned_fault, 0);
        imem_req_ready = 1;
        wait_accept(a);
        chk("trap_accept", a, 32'h8000_0200);

        // misaligned redirect: fault pulse, PC held, halt, then resume
        imem_req_ready = 0;
        wait_req(20);
        p = imem_req_addr;
        redirect_valid = 1; redirect_target = 32'h8000_0102;
        tick();
        redirect_valid = 0;
        chk("mis_fault_hi", misaligned_fault, 1);
        chk("mis_halt_noreq", imem_req_valid, 0);
        imem_req_ready = 1;
        tick();
        chk("mis_fault_lo", misaligned_fault, 0);
        repeat (4) begin
            tick();
            chk("mis_halt_idle", imem_req_valid, 0);
            chk("mis_pc_held", imem_req_addr, p);
        end
        redirect_valid = 1; redirect_target = 32'h8000_0010;
        tick();
        redirect_valid = 0;
        wait_accept(a);
        chk("mis_resume", a, 32'h8000_0010);

        // reset in the middle of a fetch; late response must be ignored
        wait_inst(20);
        tick();
        dly = 2;
        wait_accept(a);
        #3 rst = 1'b1;
        #1 chk_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        imem_resp_valid = 1; imem_resp_data = 32'hDEAD_BEEF;
        dly = 0;
        tick();
        wait_accept(a);
        chk("midrst_restart", a, 32'h8000_0000);
        wait_inst(10);
        chk("midrst_data", inst_data, mem_word(32'h8000_0000));

        // PC increment wraps at the top of the address space
        redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 0;
        wait_inst(20);
        chk("wrap_top", inst_pc, 32'hFFFF_FFFC);
        tick();
        wait_inst(20);
        chk("wrap_zero", inst_pc, 32'h0000_0000);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready  = ($urandom_range(3) != 0);
            inst_ready      = ($urandom_range(3) != 0);
            dly             = int'($urandom_range(2));
            redirect_valid  = ($urandom_range(99) < (halted ? 20 : 4));
            redirect_target = 32'h8000_0000 + ($urandom_range(255) << 2)
                              + (($urandom_range(3) == 0) ? $urandom_range(3, 1) : 32'd0);
            trap_valid      = ($urandom_range(99) < 2);
            trap_vector     = $urandom;
            tick();
        end
        redirect_valid = 0; trap_valid = 0;
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the program counter and the instruction-memory handshake for the core's fetch stage.
- Holds the PC and issues one instruction fetch at a time.
- Buffers the returned instruction until decode accepts it.
- Applies branch/jump redirects and trap entry, and discards any in-flight fetch those events make stale.
- Sits between the PC/ALU redirect sources, the instruction memory port, and decode.

Parameters:
- N, 32, address/data width.
- RESET_PC, 32'h80000000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  branch/jump taken this cycle (pc_select from execute).
- redirect_target  in  N  redirect address (alu_result).
- trap_valid  in  1  trap entry request.
- trap_vector  in  N  trap handler address; bits [1:0] are ignored (treated as 0).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  N  fetch address (current PC).
- imem_resp_valid  in  1  fetch data returned (1-cycle pulse per accepted request).
- imem_resp_data  in  N  fetched instruction.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts instruction.
- inst_data  out  N  buffered instruction.
- inst_pc  out  N  address of inst_data.
- misaligned_fault  out  1  one-cycle pulse: redirect target not 4-byte aligned.

Behaviour:
- Reset (async, any state):
  - pc=RESET_PC; state=IDLE; kill=0.
  - imem_req_valid=0, inst_valid=0, misaligned_fault=0.
  - inst_data=0, inst_pc=0.
- States: IDLE, REQ, WAIT, OUT, HALT.
- IDLE: one cycle after reset deasserts, then -> REQ. Nothing is issued.
- REQ:
  - imem_req_valid=1 and imem_req_addr=pc.
  - On imem_req_ready -> WAIT.
  - Valid/address stay stable until accepted, unless a redirect occurs.
- WAIT:
  - At most one outstanding request.
  - On imem_resp_valid with kill=0: inst_data<=resp, inst_pc<=pc, -> OUT.
  - On imem_resp_valid with kill=1: drop data, kill<=0, -> REQ.
- OUT:
  - inst_valid=1.
  - On inst_ready: pc<=pc+4 (mod 2^N, wraps), -> REQ.
  - Fetch-to-decode latency, zero-wait memory: req accepted cycle t, resp t+1, inst_valid t+2.
- Redirect priority: trap_valid > redirect_valid > sequential. The effective target is trap_vector&~3 or redirect_target.
- Redirect in REQ, request not accepted: pc<=target, stay REQ. The new address appears next cycle.
- Redirect in REQ, imem_req_ready in the same cycle: the old request is accepted. pc<=target, kill<=1, -> WAIT.
- Redirect in WAIT without resp: pc<=target, kill<=1.
- Redirect in WAIT with resp the same cycle: discard resp, pc<=target, kill<=0, -> REQ.
- Redirect in OUT (with or without inst_ready): drop the buffer, inst_valid<=0, pc<=target, -> REQ. No pc+4 is applied.
- Redirect in IDLE or HALT: pc<=target, -> REQ.
- Misaligned redirect (redirect_target[1:0]!=0, no trap):
  - misaligned_fault pulses one cycle and pc is unchanged.
  - An outstanding fetch is killed as for a redirect.
  - FSM -> HALT once no request is outstanding. HALT issues nothing until the next trap or aligned redirect.
  - A trap in the same cycle wins and no fault is raised.
- inst_valid is never combinationally dependent on inst_ready.

Decomposition:
- Shared package (fetch_pkg):
  - state enum {IDLE, REQ, WAIT, OUT, HALT}.
  - RESET_PC constant.
  - ALIGN_MASK constant (~3).
- One sub-module, fetch_pc_next: combinational next-PC select. Inputs: pc, increment enable, trap/redirect valid and targets. Outputs: next pc, misaligned flag.
- The pc itself is an instance of the existing resettable register primitive, with INIT=RESET_PC.

Test Plan:
- Reset, memory always ready, resp 1 cycle later, inst_ready=1 -> imem_req_addr sequence 0x80000000, 0x80000004, 0x80000008. inst_pc matches, one instruction every 3 cycles.
- Hold inst_ready=0 for 5 cycles in OUT -> inst_valid, inst_data, inst_pc stable and no new imem request. Release -> pc advances by exactly 4.
- redirect_valid with target 0x80000100 while in WAIT -> that response is dropped (inst_valid stays 0). Next request addr is 0x80000100.
- trap_valid (vector 0x80000203) and redirect_valid (0x80000040) in the same cycle -> next fetch addr 0x80000200, misaligned_fault=0.
- redirect_target=0x80000102 -> misaligned_fault for 1 cycle, pc unchanged, FSM in HALT with no requests. Then aligned redirect 0x80000010 -> fetch resumes there.
- Assert rst mid-WAIT, then memory returns the response -> outputs immediately 0. The late resp is ignored and the fetch restarts at 0x80000000.
